// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: non-speculative fetch stage, one outstanding imem read, PC+4/branch next-PC select.
// Optional feature: define IFU_MISALIGN_TRAP_EN to trap on a misaligned next PC instead of aligning it.
module instr_fetch_unit #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            instr_valid_o,
  input  logic            stall_i,
  input  logic            pc_src_i,
  input  logic [XLEN-1:0] imm_ext_i,
  output logic            fetch_err_o
);
`ifdef IFU_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, ipc_q, ipc_d, tgt;
  logic [31:0]     instr_q, instr_d;
  // State and fetch/instruction registers; reset drops any outstanding response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      ipc_q   <= RESET_PC;
      instr_q <= 32'h0000_0013;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
    end
  end
  // Next state: request, wait for data, hold until downstream accepts and picks the next PC
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    tgt     = pc_src_i ? ipc_q + imm_ext_i : ipc_q + XLEN'(4);
    case (state_q)
      S_REQ:  if (imem_gnt_i) state_d = S_WAIT;
      S_WAIT: if (imem_rvalid_i) begin
        state_d = S_HOLD;
        instr_d = imem_rdata_i;
        ipc_d   = pc_q;
      end
      S_HOLD: if (!stall_i) begin
`ifdef IFU_MISALIGN_TRAP_EN
        if (tgt[1:0] != 2'b00) state_d = S_ERR;
        else begin
          state_d = S_REQ;
          pc_d    = tgt;
        end
`else
        state_d = S_REQ;
        pc_d    = tgt & ~XLEN'(3);
`endif
      end
      default: state_d = state_q;
    endcase
  end
  assign imem_req_o    = rst_n && (state_q == S_REQ);
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = ipc_q;
  assign pc_plus4_o    = ipc_q + XLEN'(4);
  assign instr_valid_o = (state_q == S_HOLD);
`ifdef IFU_MISALIGN_TRAP_EN
  assign fetch_err_o   = (state_q == S_ERR);
`else
  assign fetch_err_o   = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized scoreboard bench for instr_fetch_unit with a PC-level reference model.
module tb_instr_fetch_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i, instr_valid_o, stall_i, pc_src_i, fetch_err_o;
  logic [31:0] imem_addr_o, imem_rdata_i, instr_o, pc_o, pc_plus4_o, imm_ext_i;
  typedef struct packed {logic [31:0] instr; logic [31:0] pc;} exp_t;
  exp_t        exp_instr_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] model_pc;
  int          checks = 0, errors = 0, expect_gap = 0, cyc = 0, last_hs = -1;
  bit          exp_err = 0;
  logic        pv, pstall, preq, pgnt, prv_wait;
  logic [31:0] pinstr, ppc, paddr;
  exp_t        e;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .instr_valid_o(instr_valid_o),
    .stall_i(stall_i), .pc_src_i(pc_src_i), .imm_ext_i(imm_ext_i), .fetch_err_o(fetch_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT-presented fetches and instructions against the scoreboard queues
  initial begin
    pv = 0; pstall = 0; preq = 0; pgnt = 0; prv_wait = 0; pinstr = 0; ppc = 0; paddr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_req", 32'(imem_req_o), 0);
        chk("rst_valid", 32'(instr_valid_o), 0);
        chk("rst_instr", instr_o, 32'h13);
        chk("rst_pc", pc_o, 0);
        chk("rst_pc4", pc_plus4_o, 4);
        chk("rst_addr", imem_addr_o, 0);
        chk("rst_err", 32'(fetch_err_o), 0);
        pv = 0; pstall = 0; preq = 0; pgnt = 0; prv_wait = 0; last_hs = -1;
      end else begin
        if (preq && !pgnt) begin
          chk("req_hold", 32'(imem_req_o), 1);
          chk("addr_hold", imem_addr_o, paddr);
        end
        if (pv && pstall) begin
          chk("stall_valid", 32'(instr_valid_o), 1);
          chk("stall_instr", instr_o, pinstr);
          chk("stall_pc", pc_o, ppc);
        end
        if (pv && !pstall) chk("accept_req", 32'(imem_req_o), exp_err ? 0 : 1);
        if (prv_wait) chk("rvalid_to_valid", 32'(instr_valid_o), 1);
        if (instr_valid_o) chk("no_spec_req", 32'(imem_req_o), 0);
        if (!exp_err) chk("no_err", 32'(fetch_err_o), 0);
        if (instr_valid_o && !pv) begin
          if (exp_instr_q.size() == 0) chk("instr_unexpected", instr_o, 32'hxxxx_xxxx);
          else begin
            e = exp_instr_q.pop_front();
            chk("instr", instr_o, e.instr);
            chk("pc", pc_o, e.pc);
            chk("pc_plus4", pc_plus4_o, e.pc + 32'd4);
          end
        end
        if (imem_req_o && imem_gnt_i) begin
          if (exp_addr_q.size() == 0) chk("fetch_unexpected", imem_addr_o, 32'hxxxx_xxxx);
          else chk("fetch_addr", imem_addr_o, exp_addr_q.pop_front());
          if (expect_gap != 0 && last_hs >= 0) chk("fetch_gap", 32'(cyc - last_hs), 32'(expect_gap));
          last_hs = cyc;
        end
        pv = instr_valid_o; pstall = stall_i; preq = imem_req_o; pgnt = imem_gnt_i;
        pinstr = instr_o; ppc = pc_o; paddr = imem_addr_o;
        prv_wait = imem_rvalid_i && !imem_req_o && !instr_valid_o && !fetch_err_o;
      end
    end
  end

  // One instruction transaction: gnt after gd cycles, rvalid rd cycles later, st stall cycles, then accept
  task automatic run_instr(input int gd, input int rd, input int st, input bit src,
                           input logic [31:0] imm, input logic [31:0] data, input bit stray);
    int n;
    logic [31:0] nxt;
    n = 0;
    while (!imem_req_o && n < 20) begin
      step();
      n++;
    end
    chk("req_timeout", 32'(imem_req_o), 1);
    repeat (gd) begin
      imem_gnt_i = 0; stall_i = 1'($urandom); pc_src_i = 1'($urandom); imm_ext_i = $urandom;
      step();
    end
    imem_gnt_i = 1; imem_rvalid_i = stray; imem_rdata_i = $urandom;
    step();
    imem_gnt_i = 0; imem_rvalid_i = 0;
    repeat (rd) begin
      stall_i = 1'($urandom); imem_rdata_i = $urandom;
      step();
    end
    imem_rvalid_i = 1; imem_rdata_i = data;
    exp_instr_q.push_back('{instr: data, pc: model_pc});
    step();
    imem_rvalid_i = 0; imem_rdata_i = $urandom;
    repeat (st) begin
      stall_i = 1; pc_src_i = 1'($urandom); imm_ext_i = $urandom;
      step();
    end
    stall_i = 0; pc_src_i = src; imm_ext_i = imm;
    nxt = src ? model_pc + imm : model_pc + 32'd4;
`ifdef IFU_MISALIGN_TRAP_EN
    if (nxt[1:0] != 2'b00) exp_err = 1;
    else begin
      model_pc = nxt;
      exp_addr_q.push_back(model_pc);
    end
`else
    model_pc = nxt & ~32'd3;
    exp_addr_q.push_back(model_pc);
`endif
    step();
    stall_i = 1'($urandom); pc_src_i = 1'($urandom); imm_ext_i = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] imm;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0; stall_i = 0; pc_src_i = 0; imm_ext_i = 0;
    model_pc = 0;
    exp_addr_q.push_back(32'h0);
    repeat (3) step();
    rst_n = 1;
    expect_gap = 3;
    run_instr(0, 0, 0, 0, 0, 32'h0000_0093, 0);
    repeat (3) run_instr(0, 0, 0, 0, $urandom, $urandom, 0);
    expect_gap = 0;
    run_instr(0, 0, 0, 1, 32'hFFFF_FFF8, $urandom, 0);
    run_instr(0, 0, 5, 0, 0, $urandom, 0);
    run_instr(4, 1, 0, 1, 32'hFFFF_FFFC - model_pc, $urandom, 0);
    run_instr(4, 0, 0, 0, 0, $urandom, 0);
    run_instr(0, 2, 1, 0, 0, $urandom, 1);
    repeat (40) begin
      imm = 32'($urandom_range(0, 255)) - 32'd128;
`ifdef IFU_MISALIGN_TRAP_EN
      imm = imm & ~32'd3;
`endif
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), imm,
                $urandom, 1'($urandom));
    end
    while (!imem_req_o) step();
    imem_gnt_i = 1;
    step();
    imem_gnt_i = 0;
    rst_n = 0;
    step();
    step();
    exp_addr_q.delete();
    exp_instr_q.delete();
    model_pc = 0;
    exp_addr_q.push_back(32'h0);
    rst_n = 1; imem_rvalid_i = 1; imem_rdata_i = 32'hDEAD_BEEF;
    step();
    imem_rvalid_i = 0;
    run_instr(0, 1, 0, 0, 0, $urandom, 0);
    run_instr(1, 0, 0, 1, 32'd6, $urandom, 0);
`ifdef IFU_MISALIGN_TRAP_EN
    repeat (4) step();
    chk("err_flag", 32'(fetch_err_o), 1);
    chk("err_noreq", 32'(imem_req_o), 0);
    chk("err_novalid", 32'(instr_valid_o), 0);
`else
    run_instr(0, 0, 0, 0, 0, $urandom, 0);
    repeat (3) step();
`endif
    chk("instr_q_drained", exp_instr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
